bcp_implication_scheduler: RTL
==============================

Name: bcp_implication_scheduler

Overview:
- Sequential front end of the BCP priority encoder. Collects implied-literal masks from the clause evaluators into a pending bit vector.
- Each cycle, selects the highest-indexed pending variable (highest index wins, same as priority_encoder). It issues that variable and its implied value to the assignment stage over a valid/ready handshake, then retires it from the pending set.
- Sits between the clause evaluation array (upstream) and the assignment/trail logic (downstream).

Parameters:
- VAR_NUM, 8, number of variables; width of the pending and mask vectors.
- VAR_NUM_LOG, 3, index width; must equal ceil(log2(VAR_NUM)).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all pending state (backtrack).
- imp_valid  input  1  implication mask present.
- imp_ready  output  1  scheduler accepts a mask this cycle.
- imp_mask  input  VAR_NUM  bit i set = variable i implied.
- imp_value  input  VAR_NUM  implied polarity of variable i (meaningful where imp_mask[i]=1).
- out_valid  output  1  issued implication valid.
- out_ready  input  1  downstream accepts the issued implication.
- out_var  output  VAR_NUM_LOG  issued variable index.
- out_value  output  1  issued polarity.
- busy  output  1  pending set non-empty or out_valid high.
- conflict  output  1  sticky conflict flag (optional feature).
- conflict_var  output  VAR_NUM_LOG  variable that caused the conflict (optional feature).

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, value regs=0, state=IDLE, out_valid=0, out_var=0, out_value=0, conflict=0, conflict_var=0, busy=0. imp_ready=1 after reset release.
- State machine states: IDLE, ISSUE, CONFLICT.
  - IDLE: out_valid=0.
  - ISSUE: out_valid=1.
  - CONFLICT: out_valid=0, imp_ready=0. The state is sticky; only clear or reset leaves it.
- imp_ready = (state != CONFLICT). A mask is accepted on a rising edge with imp_valid && imp_ready.
- Merge on accept: pending |= imp_mask. For each bit where imp_mask[i]=1 and pending[i]=0, value[i] <= imp_value[i]. Bits already pending keep their stored value.
- Selection: the highest index i with pending[i]=1, taken from the registered pending vector only.
  - A mask accepted at edge t is first eligible for selection in the cycle after t. out_valid therefore rises after edge t+1 at the earliest; minimum latency is 2 cycles.
- Load: the output register loads when (out_valid==0 || out_ready==1) and pending != 0.
  - out_var <= selected index, out_value <= value[index], out_valid <= 1, pending[index] <= 0.
  - State becomes ISSUE.
- Handshake completes with out_valid && out_ready.
  - If pending is empty at that point: out_valid <= 0, state becomes IDLE.
  - If pending is non-empty: the next index loads in the same edge, giving back-to-back issue of 1 per cycle.
- Backpressure: while out_valid && !out_ready, out_var and out_value stay stable and pending is not popped. Merges continue.
- Simultaneous merge and pop in the same edge:
  - The popped bit is cleared.
  - If the same bit is set again by imp_mask, it stays pending with the new value.
  - The new set takes priority over the pop clear for that bit.
- clear: synchronous, highest priority over imp and pop in the same edge. Effect: pending=0, out_valid=0, conflict=0, state=IDLE. imp_mask is ignored that cycle.
- busy = (pending != 0) || out_valid. Purely combinational from registers.
- Pending full (all VAR_NUM bits set) is legal. A further mask only updates values of non-pending bits; nothing is lost.

Optional Feature:
- Macro: BCP_CONFLICT_DETECT_EN.
- Defined: on accept, a conflict occurs for variable i if imp_mask[i]=1 and either:
  - pending[i]=1 and value[i] != imp_value[i], or
  - out_valid=1, out_var=i and out_value != imp_value[i].
- On conflict:
  - conflict <= 1 and conflict_var <= highest such i.
  - pending <= 0 and out_valid <= 0; the mask is dropped.
  - State becomes CONFLICT, so imp_ready=0 on the next cycle.
- A conflict edge overrides any handshake in the same edge; an issue in progress is discarded.
- Not defined: no conflict check. conflict and conflict_var are tied to 0, the CONFLICT state is unreachable, and imp_ready is constantly 1.

Test Plan:
- Reset then one mask=8'b0010_0100, value=8'b0000_0100, out_ready=1 -> out_valid at edge t+1 with var=5,val=0; next cycle var=2,val=1; then out_valid=0, busy=0.
- out_ready=0 for 5 cycles with pending=8'b1000_0001 -> out_var=7 held stable all 5 cycles, pending bit0 retained; release -> var=0 next cycle.
- Mask 8'hFF (all values 1) then mask 8'h01 with value 0, no conflict feature -> issue order 7..0 on consecutive cycles; var=0 issued with value 1.
- BCP_CONFLICT_DETECT_EN: mask bit3 value 1, then mask bit3 value 0 while bit3 still pending -> conflict=1, conflict_var=3, out_valid=0, imp_ready=0; clear -> conflict=0, state IDLE, imp_ready=1.
- clear asserted in the same cycle as imp_valid with mask=8'h10 and an active handshake -> pending=0, out_valid=0 afterwards; mask 8'h10 never issued.
- Async reset asserted mid-stream with out_valid=1 -> out_valid, busy and conflict drop immediately without a clock edge.

Source files
------------

// File: rtl/bcp_implication_scheduler.sv
// BCP implication scheduler: merges implied-literal masks into a pending set and
// issues the highest-indexed pending variable over valid/ready. Optional conflict
// detection is enabled by defining BCP_CONFLICT_DETECT_EN.
module bcp_implication_scheduler #(
    parameter int VAR_NUM     = 8,
    parameter int VAR_NUM_LOG = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   imp_valid,
    output logic                   imp_ready,
    input  logic [VAR_NUM-1:0]     imp_mask,
    input  logic [VAR_NUM-1:0]     imp_value,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VAR_NUM_LOG-1:0] out_var,
    output logic                   out_value,
    output logic                   busy,
    output logic                   conflict,
    output logic [VAR_NUM_LOG-1:0] conflict_var
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_CONFLICT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [VAR_NUM-1:0]     pending_q, pending_d;
    logic [VAR_NUM-1:0]     value_q, value_d;
    logic                   out_valid_q, out_valid_d;
    logic [VAR_NUM_LOG-1:0] out_var_q, out_var_d;
    logic                   out_value_q, out_value_d;
    logic                   conflict_q, conflict_d;
    logic [VAR_NUM_LOG-1:0] conflict_var_q, conflict_var_d;

    logic                   sel_valid;
    logic [VAR_NUM_LOG-1:0] sel_idx;
    logic                   conflict_hit;
    logic [VAR_NUM_LOG-1:0] conflict_idx;
    logic                   accept;
    logic                   out_free;
    logic                   load;
    logic [VAR_NUM-1:0]     pop_mask;
    logic [VAR_NUM-1:0]     after_pop;
    logic [VAR_NUM-1:0]     fresh_bits;

    // Highest pending index wins; later iterations override earlier ones.
    always_comb begin
        sel_valid = |pending_q;
        sel_idx   = '0;
        for (int i = 0; i < VAR_NUM; i++) begin
            if (pending_q[i]) begin
                sel_idx = VAR_NUM_LOG'(i);
            end
        end
    end

`ifdef BCP_CONFLICT_DETECT_EN
    // A conflict is an opposite polarity against a pending bit or the bit on the output.
    always_comb begin
        conflict_hit = 1'b0;
        conflict_idx = '0;
        for (int i = 0; i < VAR_NUM; i++) begin
            if (imp_mask[i] &&
                ((pending_q[i] && (value_q[i] != imp_value[i])) ||
                 (out_valid_q && (out_var_q == VAR_NUM_LOG'(i)) && (out_value_q != imp_value[i])))) begin
                conflict_hit = 1'b1;
                conflict_idx = VAR_NUM_LOG'(i);
            end
        end
    end
`else
    assign conflict_hit = 1'b0;
    assign conflict_idx = '0;
`endif

    assign accept   = imp_valid && imp_ready;
    assign out_free = !out_valid_q || out_ready;
    assign load     = out_free && sel_valid;

    always_comb begin
        pop_mask = '0;
        if (load) begin
            pop_mask[sel_idx] = 1'b1;
        end
    end

    // Bits not pending after the pop take the newly supplied polarity.
    assign after_pop  = pending_q & ~pop_mask;
    assign fresh_bits = imp_mask & ~after_pop;

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        value_d        = value_q;
        out_valid_d    = out_valid_q;
        out_var_d      = out_var_q;
        out_value_d    = out_value_q;
        conflict_d     = conflict_q;
        conflict_var_d = conflict_var_q;

        if (clear) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
            conflict_d  = 1'b0;
            state_d     = ST_IDLE;
        end else if (accept && conflict_hit) begin
            conflict_d     = 1'b1;
            conflict_var_d = conflict_idx;
            pending_d      = '0;
            out_valid_d    = 1'b0;
            state_d        = ST_CONFLICT;
        end else begin
            pending_d = after_pop;
            if (load) begin
                out_var_d   = sel_idx;
                out_value_d = value_q[sel_idx];
                out_valid_d = 1'b1;
                state_d     = ST_ISSUE;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            if (accept) begin
                value_d   = (value_q & ~fresh_bits) | (imp_value & fresh_bits);
                pending_d = after_pop | imp_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            value_q        <= '0;
            out_valid_q    <= 1'b0;
            out_var_q      <= '0;
            out_value_q    <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_var_q <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            value_q        <= value_d;
            out_valid_q    <= out_valid_d;
            out_var_q      <= out_var_d;
            out_value_q    <= out_value_d;
            conflict_q     <= conflict_d;
            conflict_var_q <= conflict_var_d;
        end
    end

    assign imp_ready    = (state_q != ST_CONFLICT);
    assign out_valid    = out_valid_q;
    assign out_var      = out_var_q;
    assign out_value    = out_value_q;
    assign busy         = (|pending_q) || out_valid_q;
    assign conflict     = conflict_q;
    assign conflict_var = conflict_var_q;

endmodule
